// File: rtl/game_pkg.sv
// Shared constants for the game sequencer, player and render blocks.
// Build option GAME_CTRL_PAUSE_EN adds a one-hot PAUSE state (6-bit game_state).
package game_pkg;

  localparam int DEF_LIVES        = 3;
  localparam int DEF_REPEAT_DELAY = 20;
  localparam int DEF_REPEAT_RATE  = 6;
  localparam int DEF_HIT_FREEZE   = 60;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int PLAYER_W = 32;
  localparam int PLAYER_Y = 440;

  localparam int IDX_IDLE  = 0;
  localparam int IDX_LOAD  = 1;
  localparam int IDX_PLAY  = 2;
  localparam int IDX_HIT   = 3;
  localparam int IDX_OVER  = 4;
  localparam int IDX_PAUSE = 5;

`ifdef GAME_CTRL_PAUSE_EN
  localparam int STATE_W = 6;
`else
  localparam int STATE_W = 5;
`endif

  typedef enum logic [STATE_W-1:0] {
    S_IDLE  = STATE_W'(1 << IDX_IDLE),
    S_LOAD  = STATE_W'(1 << IDX_LOAD),
    S_PLAY  = STATE_W'(1 << IDX_PLAY),
    S_HIT   = STATE_W'(1 << IDX_HIT),
`ifdef GAME_CTRL_PAUSE_EN
    S_PAUSE = STATE_W'(1 << IDX_PAUSE),
`endif
    S_OVER  = STATE_W'(1 << IDX_OVER)
  } state_t;

  // Width of a counter that must hold values 0..v.
  function automatic int cnt_w(input int v);
    return $clog2(v + 1);
  endfunction

endpackage

// File: rtl/game_ctrl_if.sv
// Button/collision inputs and player/render outputs of the game sequencer.
// game_state is 6 bits wide when GAME_CTRL_PAUSE_EN is defined, else 5.
interface game_ctrl_if;
  import game_pkg::*;

  logic               frame_tick;
  logic               btn_start;
  logic               btn_left;
  logic               btn_right;
  logic               collision;
  logic               player_start;
  logic               move_left;
  logic               move_right;
  logic               game_active;
  logic [2:0]         lives;
  logic [STATE_W-1:0] game_state;

  modport master (
    output frame_tick, btn_start, btn_left, btn_right, collision,
    input  player_start, move_left, move_right, game_active, lives, game_state
  );

  modport slave (
    input  frame_tick, btn_start, btn_left, btn_right, collision,
    output player_start, move_left, move_right, game_active, lives, game_state
  );
endinterface

// File: rtl/game_ctrl_btn_repeat.sv
// One direction button: rising-edge press pulse plus frame-paced auto-repeat.
// Unaffected by GAME_CTRL_PAUSE_EN; the parent drops enable outside PLAY.
module btn_repeat
  import game_pkg::*;
#(
  parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
  parameter int REPEAT_RATE  = DEF_REPEAT_RATE
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  input  logic enable,
  input  logic frame_tick,
  output logic pulse
);

  localparam int HOLD_W = cnt_w(REPEAT_DELAY);
  localparam int RATE_W = cnt_w(REPEAT_RATE);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(REPEAT_DELAY);
  localparam logic [RATE_W-1:0] RATE_MAX = RATE_W'(REPEAT_RATE);

  logic              btn_q;
  logic              armed_q;
  logic [HOLD_W-1:0] hold_q;
  logic [RATE_W-1:0] rate_q;
  logic              press;

  assign press = btn & ~btn_q;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      btn_q   <= 1'b0;
      armed_q <= 1'b0;
      hold_q  <= '0;
      rate_q  <= '0;
      pulse   <= 1'b0;
    end else begin
      btn_q <= btn;
      pulse <= 1'b0;
      // Losing enable disarms; after that only a fresh rising edge re-arms.
      if (!enable || !btn) begin
        armed_q <= 1'b0;
        hold_q  <= '0;
        rate_q  <= '0;
      end else if (press) begin
        armed_q <= 1'b1;
        hold_q  <= '0;
        rate_q  <= '0;
        pulse   <= 1'b1;
      end else if (armed_q && frame_tick) begin
        if (hold_q != HOLD_MAX) begin
          hold_q <= hold_q + 1'b1;
          if (hold_q + 1'b1 == HOLD_MAX) pulse <= 1'b1;
        end else if (rate_q + 1'b1 == RATE_MAX) begin
          rate_q <= '0;
          pulse  <= 1'b1;
        end else begin
          rate_q <= rate_q + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/game_ctrl.sv
// Game sequencer: one-hot state machine, lives counter and move-pulse generation.
// Define GAME_CTRL_PAUSE_EN to add a PAUSE state toggled by the start button in PLAY.
module game_ctrl
  import game_pkg::*;
#(
  parameter int LIVES        = DEF_LIVES,
  parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
  parameter int REPEAT_RATE  = DEF_REPEAT_RATE,
  parameter int HIT_FREEZE   = DEF_HIT_FREEZE
) (
  input  logic        clk,
  input  logic        reset,
  game_ctrl_if.slave  bus
);

  localparam int FRZ_W = cnt_w(HIT_FREEZE);
  localparam logic [FRZ_W-1:0] FRZ_MAX    = FRZ_W'(HIT_FREEZE);
  localparam logic [2:0]       LIVES_INIT = 3'(LIVES);

  state_t           state_q, state_nxt;
  logic [2:0]       lives_q, lives_nxt;
  logic [FRZ_W-1:0] freeze_q, freeze_nxt;
  logic             start_q;
  logic             start_edge;
  logic             in_play;
  logic             pulse_l, pulse_r;
  logic             move_q;

  assign start_edge = bus.btn_start & ~start_q;
  assign in_play    = (state_q == S_PLAY);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      lives_q  <= LIVES_INIT;
      freeze_q <= '0;
      start_q  <= 1'b0;
      move_q   <= 1'b0;
    end else begin
      state_q  <= state_nxt;
      lives_q  <= lives_nxt;
      freeze_q <= freeze_nxt;
      start_q  <= bus.btn_start;
      move_q   <= bus.move_left | bus.move_right;
    end
  end

  // NOTE: every always_comb output is defaulted first so no path can infer a latch.
  always_comb begin
    state_nxt  = state_q;
    lives_nxt  = lives_q;
    freeze_nxt = freeze_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_edge) begin
          state_nxt = S_LOAD;
          lives_nxt = LIVES_INIT;
        end
      end
      S_LOAD: state_nxt = S_PLAY;
      S_PLAY: begin
        if (bus.collision) begin
          freeze_nxt = '0;
          if (lives_q <= 3'd1) begin
            lives_nxt = '0;
            state_nxt = S_OVER;
          end else begin
            lives_nxt = lives_q - 3'd1;
            state_nxt = S_HIT;
          end
        end
`ifdef GAME_CTRL_PAUSE_EN
        else if (start_edge) begin
          state_nxt = S_PAUSE;
        end
`endif
      end
      S_HIT: begin
        if (bus.frame_tick && freeze_q != FRZ_MAX) begin
          freeze_nxt = freeze_q + 1'b1;
          if (freeze_q + 1'b1 == FRZ_MAX) state_nxt = S_LOAD;
        end
      end
      S_OVER: begin
        lives_nxt = '0;
        if (start_edge) begin
          state_nxt = S_LOAD;
          lives_nxt = LIVES_INIT;
        end
      end
`ifdef GAME_CTRL_PAUSE_EN
      S_PAUSE: begin
        if (start_edge) state_nxt = S_PLAY;
      end
`endif
      default: state_nxt = S_IDLE;
    endcase
  end

  btn_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)) u_left (
    .clk        (clk),
    .reset      (reset),
    .btn        (bus.btn_left),
    .enable     (in_play & ~bus.btn_right),
    .frame_tick (bus.frame_tick),
    .pulse      (pulse_l)
  );

  btn_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)) u_right (
    .clk        (clk),
    .reset      (reset),
    .btn        (bus.btn_right),
    .enable     (in_play & ~bus.btn_left),
    .frame_tick (bus.frame_tick),
    .pulse      (pulse_r)
  );

  // Pulses decided in a cycle that left PLAY (collision, pause) are dropped here,
  // and a move right after another move is suppressed so the player gets 2 cycles.
  assign bus.move_left    = pulse_l & in_play & ~move_q;
  assign bus.move_right   = pulse_r & ~pulse_l & in_play & ~move_q;
  assign bus.player_start = state_q[IDX_LOAD];
  assign bus.game_active  = state_q[IDX_PLAY];
  assign bus.lives        = lives_q;
  assign bus.game_state   = state_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Directed self-checking bench for game_ctrl with default parameters.
// Also exercises the PAUSE state when GAME_CTRL_PAUSE_EN is defined.
module tb_game_ctrl;

  localparam int ST_IDLE  = 1;
  localparam int ST_LOAD  = 2;
  localparam int ST_PLAY  = 4;
  localparam int ST_HIT   = 8;
  localparam int ST_OVER  = 16;
  localparam int ST_PAUSE = 32;

  logic clk = 1'b0;
  logic reset = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;
  int cnt_left = 0;
  int cnt_right = 0;
  int cnt_start = 0;
  int violations = 0;
  logic prev_move = 1'b0;

  game_ctrl_if bus();

  game_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.move_left)    cnt_left++;
    if (bus.move_right)   cnt_right++;
    if (bus.player_start) cnt_start++;
    if (bus.move_left && bus.move_right) violations++;
    if (prev_move && (bus.move_left || bus.move_right)) violations++;
    prev_move = bus.move_left | bus.move_right;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic press_start();
    bus.btn_start = 1'b1;
    cyc();
    bus.btn_start = 1'b0;
  endtask

  // One-cycle collision in PLAY, then the full freeze and the re-load.
  task automatic hit_and_recover(input int exp_lives);
    bus.collision = 1'b1;
    cyc();
    bus.collision = 1'b0;
    check("hit_state", int'(bus.game_state), ST_HIT);
    check("hit_lives", int'(bus.lives), exp_lives);
    check("hit_inactive", int'(bus.game_active), 0);
    for (int k = 1; k <= 60; k++) begin
      bus.frame_tick = 1'b1;
      cyc();
      bus.frame_tick = 1'b0;
      if (k == 59) check("freeze_59", int'(bus.game_state), ST_HIT);
      if (k == 60) begin
        check("freeze_60_load", int'(bus.game_state), ST_LOAD);
        check("freeze_60_pstart", int'(bus.player_start), 1);
      end
      cyc();
    end
    check("recover_play", int'(bus.game_state), ST_PLAY);
  endtask

  initial begin
    int exp;
    int base_start;
    bus.frame_tick = 1'b0;
    bus.btn_start  = 1'b0;
    bus.btn_left   = 1'b0;
    bus.btn_right  = 1'b0;
    bus.collision  = 1'b0;

    cyc();
    cyc();
    check("rst_state", int'(bus.game_state), ST_IDLE);
    check("rst_lives", int'(bus.lives), 3);
    check("rst_pstart", int'(bus.player_start), 0);
    check("rst_moves", int'({bus.move_left, bus.move_right}), 0);
    check("rst_active", int'(bus.game_active), 0);
    reset = 1'b1;
    cyc();
    check("rel_state", int'(bus.game_state), ST_IDLE);

    // Start: LOAD for one cycle, then PLAY; a held start gives one player_start.
    bus.btn_start = 1'b1;
    cyc();
    check("start_load", int'(bus.game_state), ST_LOAD);
    check("start_pstart", int'(bus.player_start), 1);
    cyc();
    check("start_play", int'(bus.game_state), ST_PLAY);
    check("start_active", int'(bus.game_active), 1);
    check("start_pstart_off", int'(bus.player_start), 0);
    repeat (3) cyc();
    bus.btn_start = 1'b0;
    cyc();
    check("start_once", cnt_start, 1);

    // Right held 40 ticks: press pulse, then repeats at ticks 20, 26, 32, 38.
    cnt_left = 0;
    cnt_right = 0;
    bus.btn_right = 1'b1;
    cyc();
    check("right_press", int'(bus.move_right), 1);
    cyc();
    check("right_press_1cyc", int'(bus.move_right), 0);
    for (int k = 1; k <= 40; k++) begin
      bus.frame_tick = 1'b1;
      cyc();
      bus.frame_tick = 1'b0;
      exp = (k == 20 || k == 26 || k == 32 || k == 38) ? 1 : 0;
      if (k == 19 || k == 20 || k == 21 || k == 25 || k == 26 || k == 38)
        check($sformatf("right_tick%0d", k), int'(bus.move_right), exp);
      cyc();
    end
    bus.btn_right = 1'b0;
    cyc();
    check("right_total", cnt_right, 5);
    check("right_no_left", cnt_left, 0);

    // Tick on the press cycle is not counted: first repeat still 20 ticks later.
    cnt_left = 0;
    bus.btn_left   = 1'b1;
    bus.frame_tick = 1'b1;
    cyc();
    bus.frame_tick = 1'b0;
    check("left_press_tick", int'(bus.move_left), 1);
    cyc();
    for (int k = 1; k <= 20; k++) begin
      bus.frame_tick = 1'b1;
      cyc();
      bus.frame_tick = 1'b0;
      if (k == 19) check("left_tick19", int'(bus.move_left), 0);
      if (k == 20) check("left_tick20", int'(bus.move_left), 1);
      cyc();
    end
    bus.btn_left = 1'b0;
    cyc();
    check("left_total", cnt_left, 2);

    // Both pressed together: silent; releasing left does not arm right.
    cnt_left = 0;
    cnt_right = 0;
    bus.btn_left  = 1'b1;
    bus.btn_right = 1'b1;
    cyc();
    for (int k = 0; k < 30; k++) begin
      bus.frame_tick = 1'b1; cyc(); bus.frame_tick = 1'b0; cyc();
    end
    check("both_silent", cnt_left + cnt_right, 0);
    bus.btn_left = 1'b0;
    for (int k = 0; k < 25; k++) begin
      bus.frame_tick = 1'b1; cyc(); bus.frame_tick = 1'b0; cyc();
    end
    check("release_left_silent", cnt_left + cnt_right, 0);
    bus.btn_right = 1'b0;
    cyc();
    bus.btn_right = 1'b1;
    cyc();
    check("right_repress", int'(bus.move_right), 1);
    bus.btn_right = 1'b0;
    cyc();

    // Collision beats a same-cycle press; three hits end the game.
    cnt_left = 0;
    bus.btn_left = 1'b1;
    hit_and_recover(2);
    bus.btn_left = 1'b0;
    check("collide_no_move", cnt_left, 0);
    hit_and_recover(1);
    bus.collision = 1'b1;
    cyc();
    bus.collision = 1'b0;
    check("over_state", int'(bus.game_state), ST_OVER);
    check("over_lives", int'(bus.lives), 0);
    for (int k = 0; k < 3; k++) begin
      bus.frame_tick = 1'b1; cyc(); bus.frame_tick = 1'b0; cyc();
    end
    check("over_hold", int'(bus.game_state), ST_OVER);
    check("over_lives_hold", int'(bus.lives), 0);
    press_start();
    check("restart_load", int'(bus.game_state), ST_LOAD);
    check("restart_lives", int'(bus.lives), 3);
    cyc();
    check("restart_play", int'(bus.game_state), ST_PLAY);

    // Reset in PLAY with two lives left.
    hit_and_recover(2);
    reset = 1'b0;
    cyc();
    check("midrst_state", int'(bus.game_state), ST_IDLE);
    check("midrst_lives", int'(bus.lives), 3);
    check("midrst_pulses", int'({bus.player_start, bus.move_left, bus.move_right, bus.game_active}), 0);
    base_start = cnt_start;
    cnt_left = 0;
    cnt_right = 0;
    reset = 1'b1;
    repeat (3) cyc();
    check("midrst_rel_state", int'(bus.game_state), ST_IDLE);
    check("midrst_rel_pulses", cnt_start - base_start + cnt_left + cnt_right, 0);

    press_start();
    cyc();
    check("pause_pre_play", int'(bus.game_state), ST_PLAY);
    base_start = cnt_start;
    press_start();
`ifdef GAME_CTRL_PAUSE_EN
    check("pause_enter", int'(bus.game_state), ST_PAUSE);
    check("pause_inactive", int'(bus.game_active), 0);
    bus.collision = 1'b1;
    cyc();
    bus.collision = 1'b0;
    check("pause_collide_state", int'(bus.game_state), ST_PAUSE);
    check("pause_collide_lives", int'(bus.lives), 3);
    press_start();
    check("pause_resume", int'(bus.game_state), ST_PLAY);
    check("pause_no_pstart", cnt_start - base_start, 0);
`else
    check("start_in_play_ignored", int'(bus.game_state), ST_PLAY);
    check("start_in_play_no_pstart", cnt_start - base_start, 0);
`endif
    cyc();
    check("move_mutex", violations, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
